// File: rtl/tcp_tx_route_lut.sv
// tcp_tx_route_lut
// Session-to-route lookup for the TCP TX arbiter's route-ID sideband.
// A direct-mapped, tag-checked table turns a session ID into a 14-bit
// vIO-switch route. A miss returns the programmable default route.
//
// Ports
//   aclk_i, areset_i       clock, asynchronous active-high reset
//   tx_sid_i/_valid_i      level lookup request, held until the response
//   tx_route_id_o/_valid_o one-cycle response pulse carrying the route
//   cfg_wr_*               control-plane table write (valid/ready)
//   cfg_default_route_i    route returned on a miss (quasi-static)
//   cfg_clear_i            pulse: invalidate every entry, zero the counters
//   clr_busy_o             clear pending or sweeping
//   hit_cnt_o, miss_cnt_o  saturating lookup counters
//
// State | meaning
//   IDLE  | waiting for a request; a pending clear sweep may run here
//   READ  | table read of the registered index; writes are held off
//   RESP  | tag compare, response pulse, counter update
//   DONE  | wait for the arbiter to drop its request
module tcp_tx_route_lut #(
  parameter int TCP_SESSION_BITS = 16,
  parameter int LUT_DEPTH        = 1024
) (
  input  logic                        aclk_i,
  input  logic                        areset_i,
  input  logic [TCP_SESSION_BITS-1:0] tx_sid_i,
  input  logic                        tx_sid_valid_i,
  output logic [13:0]                 tx_route_id_o,
  output logic                        tx_route_id_valid_o,
  input  logic                        cfg_wr_valid_i,
  output logic                        cfg_wr_ready_o,
  input  logic [TCP_SESSION_BITS-1:0] cfg_wr_sid_i,
  input  logic                        cfg_wr_en_i,
  input  logic [13:0]                 cfg_wr_route_id_i,
  input  logic [13:0]                 cfg_default_route_i,
  input  logic                        cfg_clear_i,
  output logic                        clr_busy_o,
  output logic [31:0]                 hit_cnt_o,
  output logic [31:0]                 miss_cnt_o
);

  localparam int IDX_BITS   = $clog2(LUT_DEPTH);
  localparam int TAG_BITS   = TCP_SESSION_BITS - IDX_BITS;
  localparam int ROUTE_BITS = 14;
  localparam int ENTRY_BITS = 1 + TAG_BITS + ROUTE_BITS;
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(LUT_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, READ, RESP, DONE} state_e;

  state_e                state_q;
  logic [IDX_BITS-1:0]   idx_q;
  logic [TAG_BITS-1:0]   tag_q;
  logic                  resp_q;

  logic                  clr_pend_q, clr_pend_d;
  logic                  sweep_q, sweep_d;
  logic [IDX_BITS-1:0]   sweep_idx_q, sweep_idx_d;
  logic [31:0]           hit_cnt_q, hit_cnt_d;
  logic [31:0]           miss_cnt_q, miss_cnt_d;

  logic [ENTRY_BITS-1:0] lut_mem_q [LUT_DEPTH];
  logic [ENTRY_BITS-1:0] rd_q;

  logic                  clr_busy;
  logic                  sweep_start;
  logic                  sweep_first;
  logic                  wr_en;
  logic [IDX_BITS-1:0]   wr_idx;
  logic [ENTRY_BITS-1:0] wr_data;
  logic                  rd_vld;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [ROUTE_BITS-1:0] rd_route;
  logic                  hit;

  assign clr_busy    = clr_pend_q | sweep_q;
  // The sweep only begins from IDLE so an in-flight lookup always finishes.
  assign sweep_start = clr_pend_q && !sweep_q && (state_q == IDLE);
  assign sweep_first = sweep_q && (sweep_idx_q == '0);

  // Holding writes off during READ keeps the read free of collisions.
  assign cfg_wr_ready_o = !clr_busy && (state_q != READ);
  assign clr_busy_o     = clr_busy;

  // Sweep and control-plane writes never overlap: ready is low while busy.
  assign wr_en   = sweep_q | (cfg_wr_valid_i & cfg_wr_ready_o);
  assign wr_idx  = sweep_q ? sweep_idx_q : cfg_wr_sid_i[IDX_BITS-1:0];
  assign wr_data = sweep_q ? '0
                 : {cfg_wr_en_i, cfg_wr_sid_i[TCP_SESSION_BITS-1:IDX_BITS], cfg_wr_route_id_i};

  always_ff @(posedge aclk_i) begin
    if (wr_en) lut_mem_q[wr_idx] <= wr_data;
    if (state_q == READ) rd_q <= lut_mem_q[idx_q];
  end

  assign rd_vld   = rd_q[ENTRY_BITS-1];
  assign rd_tag   = rd_q[ROUTE_BITS +: TAG_BITS];
  assign rd_route = rd_q[ROUTE_BITS-1:0];
  assign hit      = rd_vld && (rd_tag == tag_q);

  assign tx_route_id_valid_o = resp_q;
  assign tx_route_id_o       = resp_q ? (hit ? rd_route : cfg_default_route_i) : '0;

  always_ff @(posedge aclk_i or posedge areset_i) begin
    if (areset_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      tag_q   <= '0;
      resp_q  <= 1'b0;
    end else begin
      resp_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tx_sid_valid_i && !clr_busy) begin
            idx_q   <= tx_sid_i[IDX_BITS-1:0];
            tag_q   <= tx_sid_i[TCP_SESSION_BITS-1:IDX_BITS];
            state_q <= READ;
          end
        end
        READ: begin
          resp_q  <= 1'b1;
          state_q <= RESP;
        end
        RESP: state_q <= DONE;
        DONE: begin
          if (!tx_sid_valid_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    clr_pend_d  = clr_pend_q;
    sweep_d     = sweep_q;
    sweep_idx_d = sweep_idx_q;
    if (sweep_start) begin
      clr_pend_d  = 1'b0;
      sweep_d     = 1'b1;
      sweep_idx_d = '0;
    end else begin
      // Clear pulses arriving mid-sweep are dropped.
      if (cfg_clear_i && !sweep_q) clr_pend_d = 1'b1;
      if (sweep_q) begin
        sweep_idx_d = sweep_idx_q + 1'b1;
        if (sweep_idx_q == LAST_IDX) sweep_d = 1'b0;
      end
    end
  end

  assign hit_cnt_d  = sweep_first ? '0
                    : (resp_q && hit && (hit_cnt_q != '1)) ? hit_cnt_q + 32'd1 : hit_cnt_q;
  assign miss_cnt_d = sweep_first ? '0
                    : (resp_q && !hit && (miss_cnt_q != '1)) ? miss_cnt_q + 32'd1 : miss_cnt_q;

  // A clear is pending out of reset because the table RAM powers up undefined.
  always_ff @(posedge aclk_i or posedge areset_i) begin
    if (areset_i) begin
      clr_pend_q  <= 1'b1;
      sweep_q     <= 1'b0;
      sweep_idx_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      clr_pend_q  <= clr_pend_d;
      sweep_q     <= sweep_d;
      sweep_idx_q <= sweep_idx_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;

endmodule

// File: tb/tb_tcp_tx_route_lut.sv
// Testbench for tcp_tx_route_lut: directed scenarios plus a randomized
// sequence checked against a session-keyed reference table.
module tb_tcp_tx_route_lut;

  localparam int SB    = 16;
  localparam int DEPTH = 16;

  logic          aclk = 1'b0;
  logic          areset = 1'b0;
  logic [SB-1:0] tx_sid = '0;
  logic          tx_sid_valid = 1'b0;
  logic [13:0]   tx_route_id;
  logic          tx_route_id_valid;
  logic          cfg_wr_valid = 1'b0;
  logic          cfg_wr_ready;
  logic [SB-1:0] cfg_wr_sid = '0;
  logic          cfg_wr_en = 1'b0;
  logic [13:0]   cfg_wr_route_id = '0;
  logic [13:0]   cfg_default_route = 14'h3FF;
  logic          cfg_clear = 1'b0;
  logic          clr_busy;
  logic [31:0]   hit_cnt;
  logic [31:0]   miss_cnt;

  int errors = 0;
  int checks = 0;

  // Reference: one slot per index, remembering the full session that owns it.
  bit            m_vld   [DEPTH];
  logic [SB-1:0] m_sid   [DEPTH];
  logic [13:0]   m_route [DEPTH];
  logic [31:0]   m_hit, m_miss;
  logic [13:0]   dflt = 14'h3FF;

  tcp_tx_route_lut #(.TCP_SESSION_BITS(SB), .LUT_DEPTH(DEPTH)) dut (
    .aclk_i              (aclk),
    .areset_i            (areset),
    .tx_sid_i            (tx_sid),
    .tx_sid_valid_i      (tx_sid_valid),
    .tx_route_id_o       (tx_route_id),
    .tx_route_id_valid_o (tx_route_id_valid),
    .cfg_wr_valid_i      (cfg_wr_valid),
    .cfg_wr_ready_o      (cfg_wr_ready),
    .cfg_wr_sid_i        (cfg_wr_sid),
    .cfg_wr_en_i         (cfg_wr_en),
    .cfg_wr_route_id_i   (cfg_wr_route_id),
    .cfg_default_route_i (cfg_default_route),
    .cfg_clear_i         (cfg_clear),
    .clr_busy_o          (clr_busy),
    .hit_cnt_o           (hit_cnt),
    .miss_cnt_o          (miss_cnt)
  );

  always #5 aclk = ~aclk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
    m_hit  = '0;
    m_miss = '0;
  endfunction

  function automatic void model_write(input logic [SB-1:0] sid, input logic en, input logic [13:0] route);
    int i;
    i = int'(sid) % DEPTH;
    m_vld[i]   = en;
    m_sid[i]   = sid;
    m_route[i] = route;
  endfunction

  function automatic void model_lookup(input logic [SB-1:0] sid, output logic [13:0] route, output bit hit);
    int i;
    i = int'(sid) % DEPTH;
    hit   = m_vld[i] && (m_sid[i] == sid);
    route = hit ? m_route[i] : dflt;
  endfunction

  function automatic void model_count(input bit hit);
    if (hit) begin
      if (m_hit != 32'hFFFF_FFFF) m_hit = m_hit + 32'd1;
    end else begin
      if (m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 32'd1;
    end
  endfunction

  task automatic cfg_write(input logic [SB-1:0] sid, input logic en, input logic [13:0] route);
    int n;
    n = 0;
    cfg_wr_sid = sid; cfg_wr_en = en; cfg_wr_route_id = route; cfg_wr_valid = 1'b1;
    while (!cfg_wr_ready && n < 200) begin
      @(negedge aclk);
      n++;
    end
    checks++;
    if (cfg_wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL cfg_write_ready: ready=%b after %0d cycles, required 1", cfg_wr_ready, n);
    end
    @(negedge aclk);
    cfg_wr_valid = 1'b0;
    model_write(sid, en, route);
  endtask

  // Issue one request from IDLE, hold it `hold` cycles past the pulse, and
  // return one cycle after the FSM is back in IDLE.
  task automatic lookup(input logic [SB-1:0] sid, input int hold, input string name);
    logic [13:0] er;
    bit eh;
    int lat, extra;
    model_lookup(sid, er, eh);
    tx_sid = sid;
    tx_sid_valid = 1'b1;
    lat = 0;
    do begin
      @(negedge aclk);
      lat++;
    end while (!tx_route_id_valid && lat < 50);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, required 2", name, lat);
    end
    checks++;
    if (tx_route_id !== er) begin
      errors++;
      $display("FAIL %s route: got %h, required %h", name, tx_route_id, er);
    end
    model_count(eh);
    extra = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge aclk);
      if (tx_route_id_valid) extra++;
    end
    tx_sid_valid = 1'b0;
    @(negedge aclk);
    if (tx_route_id_valid) extra++;
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL %s extra_pulses: got %0d, required 0", name, extra);
    end
    checks++;
    if (hit_cnt !== m_hit) begin
      errors++;
      $display("FAIL %s hit_cnt: got %h, required %h", name, hit_cnt, m_hit);
    end
    checks++;
    if (miss_cnt !== m_miss) begin
      errors++;
      $display("FAIL %s miss_cnt: got %h, required %h", name, miss_cnt, m_miss);
    end
    @(negedge aclk);
  endtask

  task automatic test_reset();
    #2 areset = 1'b1;
    #4;
    checks++;
    if (tx_route_id !== 14'h0 || tx_route_id_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_resp: route=%h valid=%b, required 0/0", tx_route_id, tx_route_id_valid);
    end
    checks++;
    if (cfg_wr_ready !== 1'b0 || clr_busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b busy=%b, required 0/1", cfg_wr_ready, clr_busy);
    end
    checks++;
    if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin
      errors++;
      $display("FAIL reset_cnt: hit=%h miss=%h, required 0/0", hit_cnt, miss_cnt);
    end
    @(negedge aclk);
    areset = 1'b0;
    for (int k = 1; k <= DEPTH + 1; k++) begin
      @(negedge aclk);
      if (k == DEPTH) begin
        checks++;
        if (cfg_wr_ready !== 1'b0 || clr_busy !== 1'b1) begin
          errors++;
          $display("FAIL autoclear_end-1: ready=%b busy=%b, required 0/1", cfg_wr_ready, clr_busy);
        end
      end
      if (k == DEPTH + 1) begin
        checks++;
        if (cfg_wr_ready !== 1'b1 || clr_busy !== 1'b0) begin
          errors++;
          $display("FAIL autoclear_end: ready=%b busy=%b, required 1/0", cfg_wr_ready, clr_busy);
        end
      end
    end
    model_clear();
  endtask

  task automatic test_programmed_hit();
    cfg_write(16'h0123, 1'b1, 14'h2A5);
    lookup(16'h0123, 0, "programmed_hit");
  endtask

  task automatic test_tag_miss();
    lookup(16'h0133, 0, "tag_miss");
  endtask

  task automatic test_invalidate_overwrite();
    cfg_write(16'h0123, 1'b0, 14'h0);
    lookup(16'h0123, 0, "invalidated");
    cfg_write(16'h0133, 1'b1, 14'h011);
    lookup(16'h0133, 0, "overwrite");
  endtask

  task automatic test_held_request();
    lookup(16'h0133, 6, "held_request");
  endtask

  task automatic test_same_cycle();
    checks++;
    if (cfg_wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle_ready: ready=%b, required 1", cfg_wr_ready);
    end
    cfg_wr_sid = 16'h0456; cfg_wr_en = 1'b1; cfg_wr_route_id = 14'h1234; cfg_wr_valid = 1'b1;
    model_write(16'h0456, 1'b1, 14'h1234);
    fork
      begin
        @(negedge aclk);
        cfg_wr_valid = 1'b0;
      end
    join_none
    lookup(16'h0456, 0, "same_cycle");
  endtask

  task automatic test_clear_mid_lookup();
    logic [13:0] er;
    bit eh;
    int busy_cnt, fall, pulse;
    cfg_write(16'h0789, 1'b1, 14'h0ABC);
    model_lookup(16'h0789, er, eh);
    tx_sid = 16'h0789;
    tx_sid_valid = 1'b1;
    @(negedge aclk);
    cfg_clear = 1'b1;
    @(negedge aclk);
    cfg_clear = 1'b0;
    checks++;
    if (tx_route_id_valid !== 1'b1 || tx_route_id !== er) begin
      errors++;
      $display("FAIL clear_mid_resp: valid=%b route=%h, required 1/%h", tx_route_id_valid, tx_route_id, er);
    end
    checks++;
    if (clr_busy !== 1'b1) begin
      errors++;
      $display("FAIL clear_mid_busy: busy=%b, required 1", clr_busy);
    end
    tx_sid_valid = 1'b0;
    model_clear();
    busy_cnt = 1; fall = -1; pulse = -1;
    for (int cyc = 3; cyc < 80 && pulse < 0; cyc++) begin
      @(negedge aclk);
      if (clr_busy) busy_cnt++;
      else if (fall < 0) fall = cyc;
      if (tx_route_id_valid) begin
        pulse = cyc;
        checks++;
        if (tx_route_id !== dflt) begin
          errors++;
          $display("FAIL clear_after_route: got %h, required %h", tx_route_id, dflt);
        end
      end
      if (cyc == 10) begin
        checks++;
        if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin
          errors++;
          $display("FAIL clear_counters: hit=%h miss=%h, required 0/0", hit_cnt, miss_cnt);
        end
      end
      if (cyc == 6) begin
        tx_sid = 16'h0789;
        tx_sid_valid = 1'b1;
      end
    end
    // busy from T+2; the FSM reaches IDLE at T+4, the sweep occupies T+5..T+20
    checks++;
    if (busy_cnt !== DEPTH + 3) begin
      errors++;
      $display("FAIL clear_busy_len: got %0d cycles, required %0d", busy_cnt, DEPTH + 3);
    end
    checks++;
    if (pulse < 0 || pulse !== fall + 2) begin
      errors++;
      $display("FAIL clear_serve_latency: pulse at %0d, busy fell at %0d, required fall+2", pulse, fall);
    end
    model_count(1'b0);
    tx_sid_valid = 1'b0;
    @(negedge aclk);
    checks++;
    if (miss_cnt !== m_miss || hit_cnt !== m_hit) begin
      errors++;
      $display("FAIL clear_after_cnt: hit=%h miss=%h, required %h/%h", hit_cnt, miss_cnt, m_hit, m_miss);
    end
    @(negedge aclk);
  endtask

  task automatic test_random();
    logic [SB-1:0] pool [6];
    logic [SB-1:0] sid;
    int op;
    pool = '{16'h0123, 16'h0133, 16'h0A43, 16'h0125, 16'h7FF5, 16'h0001};
    for (int i = 0; i < 40; i++) begin
      op  = int'($urandom_range(0, 5));
      sid = pool[$urandom_range(0, 5)];
      case (op)
        0, 1: cfg_write(sid, 1'b1, 14'($urandom));
        2:    cfg_write(sid, 1'b0, 14'($urandom));
        3: begin
          dflt = 14'($urandom);
          cfg_default_route = dflt;
          @(negedge aclk);
        end
        default: lookup(sid, int'($urandom_range(0, 2)), "random");
      endcase
    end
  endtask

  task automatic test_reset_mid_op();
    int pulses;
    tx_sid = 16'h0123;
    tx_sid_valid = 1'b1;
    @(negedge aclk);
    areset = 1'b1;
    #1;
    checks++;
    if (tx_route_id_valid !== 1'b0 || tx_route_id !== 14'h0 || cfg_wr_ready !== 1'b0 ||
        clr_busy !== 1'b1 || hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_lookup: valid=%b route=%h ready=%b busy=%b hit=%h miss=%h, required 0/0/0/1/0/0",
               tx_route_id_valid, tx_route_id, cfg_wr_ready, clr_busy, hit_cnt, miss_cnt);
    end
    tx_sid_valid = 1'b0;
    @(negedge aclk);
    areset = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(negedge aclk);
      if (tx_route_id_valid) pulses++;
    end
    checks++;
    if (pulses !== 0 || clr_busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_no_pulse: pulses=%0d busy=%b, required 0/1", pulses, clr_busy);
    end
    areset = 1'b1;
    #1;
    checks++;
    if (cfg_wr_ready !== 1'b0 || clr_busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_sweep: ready=%b busy=%b, required 0/1", cfg_wr_ready, clr_busy);
    end
    @(negedge aclk);
    areset = 1'b0;
    for (int k = 1; k <= DEPTH + 1; k++) begin
      @(negedge aclk);
      if (k == DEPTH) begin
        checks++;
        if (cfg_wr_ready !== 1'b0) begin
          errors++;
          $display("FAIL resweep_end-1: ready=%b, required 0", cfg_wr_ready);
        end
      end
      if (k == DEPTH + 1) begin
        checks++;
        if (cfg_wr_ready !== 1'b1) begin
          errors++;
          $display("FAIL resweep_end: ready=%b, required 1", cfg_wr_ready);
        end
      end
    end
    model_clear();
    lookup(16'h0456, 0, "after_reset");
  endtask

  task automatic test_saturation();
    @(negedge aclk);
    force dut.miss_cnt_d = 32'hFFFF_FFFE;
    @(negedge aclk);
    release dut.miss_cnt_d;
    m_miss = 32'hFFFF_FFFE;
    checks++;
    if (miss_cnt !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL sat_preload: got %h, required fffffffe", miss_cnt);
    end
    for (int i = 0; i < 3; i++) lookup(16'h0AB0 + 16'(i), 0, "saturation");
  endtask

  initial begin
    test_reset();
    test_programmed_hit();
    test_tag_miss();
    test_invalidate_overwrite();
    test_held_request();
    test_same_cycle();
    test_clear_mid_lookup();
    test_random();
    test_reset_mid_op();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tcp_tx_route_lut.md
# tcp_tx_route_lut

Session-to-route lookup table that answers the TCP TX arbiter's route-ID sideband request. During its route-wait state the arbiter presents a session ID (`tx_sid`, held with `tx_sid_valid`). This block returns a 14-bit vIO-switch `route_id` as a one-cycle `tx_route_id_valid` pulse, which the arbiter then uses to tag the outgoing TCP payload. The table is direct-mapped with tag check and is programmed through a control-plane write port. A miss returns a programmable default route.

## Interface
- `LUT_DEPTH`, 1024: table entries; power of two, 2 ≤ `LUT_DEPTH` < 2**`TCP_SESSION_BITS`.
- `IDX_BITS`, `$clog2(LUT_DEPTH)`: index width (derived, not overridable).
- `aclk` in 1: clock.
- `areset` in 1: reset, asynchronous, active-high.
- `tx_sid` in `TCP_SESSION_BITS`: session ID; sampled only in IDLE when `tx_sid_valid`=1.
- `tx_sid_valid` in 1: level request from the arbiter; held until the response pulse is observed.
- `tx_route_id` out 14: lookup result; valid only while `tx_route_id_valid`=1.
- `tx_route_id_valid` out 1: one-cycle response pulse.
- `cfg_wr_valid` in 1: table write request.
- `cfg_wr_ready` out 1: write accepted when valid && ready.
- `cfg_wr_sid` in `TCP_SESSION_BITS`: session to program.
- `cfg_wr_en` in 1: 1 = install entry; 0 = invalidate entry at that index.
- `cfg_wr_route_id` in 14: route to install.
- `cfg_default_route` in 14: route returned on miss; quasi-static.
- `cfg_clear` in 1: pulse; invalidates all entries and zeroes the counters.
- `clr_busy` out 1: high while a clear is pending or sweeping.
- `hit_cnt` out 32: saturating lookup-hit counter.
- `miss_cnt` out 32: saturating lookup-miss counter.

## Operation
- Entry format is {vld, tag[`TCP_SESSION_BITS`-`IDX_BITS`], route[14]}.
  - idx = sid[`IDX_BITS`-1:0]; tag = sid[`TCP_SESSION_BITS`-1:`IDX_BITS`].
  - Stored in simple dual-port RAM with registered read; RAM contents are not reset.
- Lookup FSM states:
  - IDLE → READ when `tx_sid_valid` && !`clr_busy`. In that cycle, register idx and tag from `tx_sid`.
  - READ: RAM read of the registered idx → RESP.
  - RESP: hit = vld && (stored tag == registered tag). Drive `tx_route_id_valid`=1 and `tx_route_id` = hit ? stored route : `cfg_default_route`. Increment `hit_cnt` or `miss_cnt` → DONE.
  - DONE: wait for `tx_sid_valid`=0 → IDLE. This prevents a second response to the still-asserted request.
- Config write:
  - Accepted on `cfg_wr_valid` && `cfg_wr_ready`.
  - `cfg_wr_en`=1 writes {1, tag, route} to the entry at idx.
  - `cfg_wr_en`=0 writes vld=0 at that idx, regardless of tag.
  - A new session aliasing the same idx overwrites the previous entry.
- `cfg_wr_ready` = !`clr_busy` && (state != READ). This removes any read/write collision, so the result reflects all writes accepted before READ.
- Clear:
  - `cfg_clear` sets a pending flag. The sweep starts once the FSM is in IDLE; an in-flight lookup completes first.
  - The sweep writes vld=0 to idx 0..`LUT_DEPTH`-1, one entry per cycle, and zeroes both counters on its first cycle.
  - `clr_busy`=1 from the cycle after the `cfg_clear` pulse until the cycle after the last sweep write.
  - Pulses of `cfg_clear` during a sweep are ignored.
- Auto-clear: an automatic sweep runs after reset release, because RAM contents are undefined.
- Counters saturate at 0xFFFFFFFF; they do not wrap.

## Timing
- Reset values:
  - `tx_route_id`=0, `tx_route_id_valid`=0, `cfg_wr_ready`=0, `hit_cnt`=0, `miss_cnt`=0.
  - `clr_busy`=1, because auto-clear is pending.
  - FSM state = IDLE.
- Reset asserted mid-operation aborts any lookup or sweep. No response pulse is emitted. The sweep restarts from idx 0 after release.
- Latency for a request first seen in IDLE at cycle T:
  - `tx_route_id_valid`=1 at T+2 for exactly one cycle.
  - Counter update is visible at T+3.
- Back-to-back lookups: the earliest re-accept is the first cycle `tx_sid_valid` is low in DONE + 1. With the arbiter's behaviour, the minimum spacing is 5 cycles.
- Auto-clear duration: `LUT_DEPTH` cycles. `cfg_wr_ready` rises at reset-release + `LUT_DEPTH` + 1.
- A request arriving while `clr_busy`=1 stays in IDLE. It is served at T+2 after `clr_busy` falls, with the table fully invalid, so it misses.
- A write and a request in the same IDLE cycle: the write is accepted and the request enters READ in the same cycle. The lookup sees the new entry.

## Test plan
- Programmed hit:
  - Setup: `LUT_DEPTH`=16; wait for `clr_busy`=0; write sid 0x0123, route 0x2A5, `cfg_wr_en`=1.
  - Stimulus: request sid 0x0123 at T.
  - Expected: pulse at T+2 with `tx_route_id`=0x2A5; `hit_cnt`=1.
- Tag miss:
  - Stimulus: request sid 0x0133 (same idx 3, different tag).
  - Expected: `tx_route_id`=`cfg_default_route`=0x3FF; `miss_cnt`=1.
- Invalidate and overwrite:
  - Stimulus: write sid 0x0123 with `cfg_wr_en`=0, then request 0x0123; next, write sid 0x0133 with route 0x011, then request 0x0133.
  - Expected: the 0x0123 request misses; the 0x0133 request hits with 0x011.
- Held request:
  - Stimulus: hold `tx_sid_valid` for 6 cycles.
  - Expected: exactly one pulse; the FSM stays in DONE until valid drops.
- Clear mid-lookup:
  - Stimulus: pulse `cfg_clear` at T+1 of a lookup.
  - Expected: the pulse still occurs at T+2 with the old value; `clr_busy` stays high for 16 sweep cycles; the counters read 0; a request during the sweep is answered 2 cycles after `clr_busy` falls, as a miss.
- Reset and saturation:
  - Stimulus: assert `areset` mid-sweep; separately, force `miss_cnt` to 0xFFFFFFFE and issue 3 misses.
  - Expected: all outputs at reset values and the sweep restarts from idx 0; `miss_cnt` holds at 0xFFFFFFFF.
